// File: rtl/approx_mon_pkg.sv
// Shared types and helpers for the approximate-arithmetic error monitors.
package approx_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_t;

    localparam int W_DEF     = 12;
    localparam int CNT_W_DEF = 24;

    // Add two values and clamp to the all-ones value of a width-bit register (width <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input int          width);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << width) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Combinational error slice: exact sum, signed error, magnitude and square.
module approx_err_calc #(
    parameter int W = 12
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W:0]     o_approx,
    output logic [W:0]     abs_err,
    output logic           nonzero,
    output logic [2*W+1:0] sq_err
);

    logic [W:0]          exact;
    logic signed [W+1:0] err;

    assign exact   = {1'b0, a} + {1'b0, b};
    assign err     = $signed({1'b0, exact}) - $signed({1'b0, o_approx});
    // The magnitude never exceeds 2^(W+1)-1, so the sign bit can be dropped after negation.
    assign abs_err = err[W+1] ? (~err[W:0] + (W+1)'(1)) : err[W:0];
    assign nonzero = |err;
    assign sq_err  = {{(W+1){1'b0}}, abs_err} * {{(W+1){1'b0}}, abs_err};

endmodule

// File: rtl/approx_add_err_monitor.sv
// Error-statistics monitor for an approximate unsigned adder: FSM, two-stage
// pipeline and saturating accumulators for sample count, EP, MAE, MSE and WCE.
module approx_add_err_monitor
    import approx_mon_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SUM_W = CNT_W + W + 1,
    parameter int SQ_W  = CNT_W + 2 * (W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W:0]       o_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [SQ_W-1:0]  sum_sq_err,
    output logic [W:0]       max_err,
    output logic [W-1:0]     wce_a,
    output logic [W-1:0]     wce_b
);

    mon_state_t       state;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] acc_cnt;
    logic             start_ok;
    logic             accept;
    logic             last_accept;

    logic [W:0]       abs_err;
    logic             nonzero;
    logic [2*W+1:0]   sq_err;

    logic             vld_p1;
    logic [W:0]       abs_p1;
    logic             nz_p1;
    logic [2*W+1:0]   sq_p1;
    logic [W-1:0]     a_p1;
    logic [W-1:0]     b_p1;

    assign start_ok    = start && (state == IDLE || state == DONE);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && ((acc_cnt + CNT_W'(1)) == n_lat);

    approx_err_calc #(.W(W)) u_calc (
        .a        (a),
        .b        (b),
        .o_approx (o_approx),
        .abs_err  (abs_err),
        .nonzero  (nonzero),
        .sq_err   (sq_err)
    );

    // in_ready, busy and done are registered so they depend only on state and the accept count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n_lat    <= '0;
            acc_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        acc_cnt <= '0;
                        if (n_samples != '0) begin
                            state    <= RUN;
                            n_lat    <= n_samples;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (last_accept) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!vld_p1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // S1: capture the error terms and operands of each accepted triple
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            abs_p1 <= '0;
            nz_p1  <= 1'b0;
            sq_p1  <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
        end else begin
            vld_p1 <= accept && !start_ok;
            if (accept) begin
                abs_p1 <= abs_err;
                nz_p1  <= nonzero;
                sq_p1  <= sq_err;
                a_p1   <= a;
                b_p1   <= b;
            end
        end
    end

    // S2: saturating accumulation; strict compare keeps the earliest worst-case sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
            max_err     <= '0;
            wce_a       <= '0;
            wce_b       <= '0;
        end else if (start_ok) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
            max_err     <= '0;
            wce_a       <= '0;
            wce_b       <= '0;
        end else if (vld_p1) begin
            sample_cnt  <= CNT_W'(sat_add(64'(sample_cnt), 64'd1, CNT_W));
            err_cnt     <= CNT_W'(sat_add(64'(err_cnt), 64'(nz_p1), CNT_W));
            sum_abs_err <= SUM_W'(sat_add(64'(sum_abs_err), 64'(abs_p1), SUM_W));
            sum_sq_err  <= SQ_W'(sat_add(64'(sum_sq_err), 64'(sq_p1), SQ_W));
            if (abs_p1 > max_err) begin
                max_err <= abs_p1;
                wce_a   <= a_p1;
                wce_b   <= b_p1;
            end
        end
    end

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Scenario bench for approx_add_err_monitor with a queue of expected run statistics.
module tb_approx_add_err_monitor;
    import approx_mon_pkg::*;

    localparam int W     = 12;
    localparam int CNT_W = 24;
    localparam int SUM_W = CNT_W + W + 1;
    localparam int SQ_W  = CNT_W + 2 * (W + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] n_samples;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W:0]       o_approx;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [SUM_W-1:0] sum_abs_err;
    logic [SQ_W-1:0]  sum_sq_err;
    logic [W:0]       max_err;
    logic [W-1:0]     wce_a;
    logic [W-1:0]     wce_b;

    approx_add_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W), .SQ_W(SQ_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .n_samples   (n_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .o_approx    (o_approx),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .sum_abs_err (sum_abs_err),
        .sum_sq_err  (sum_sq_err),
        .max_err     (max_err),
        .wce_a       (wce_a),
        .wce_b       (wce_b)
    );

    typedef struct packed {
        logic [63:0] cnt;
        logic [63:0] errc;
        logic [63:0] sabs;
        logic [63:0] ssq;
        logic [63:0] maxe;
        logic [63:0] wa;
        logic [63:0] wb;
    } stats_t;

    stats_t exp_q[$];
    stats_t m;
    stats_t got;
    stats_t exp;
    int     total;
    int     passed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stats_t dut_stats();
        return '{64'(sample_cnt), 64'(err_cnt), 64'(sum_abs_err), 64'(sum_sq_err),
                 64'(max_err), 64'(wce_a), 64'(wce_b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m = '0;
    endtask

    task automatic model_accept(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [W:0] xo);
        longint e;
        longint ae;
        e  = longint'(xa) + longint'(xb) - longint'(xo);
        ae = (e < 0) ? -e : e;
        m.cnt  = m.cnt + 1;
        if (ae != 0) m.errc = m.errc + 1;
        m.sabs = m.sabs + 64'(ae);
        m.ssq  = m.ssq + 64'(ae * ae);
        if (64'(ae) > m.maxe) begin
            m.maxe = 64'(ae);
            m.wa   = 64'(xa);
            m.wb   = 64'(xb);
        end
    endtask

    task automatic start_run(input int n);
        start     = 1'b1;
        n_samples = CNT_W'(n);
        model_clear();
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [W:0] xo);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        o_approx = xo;
        for (int i = 0; i < 20; i++) begin
            acc = in_ready;
            if (acc) model_accept(xa, xb, xo);
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        total++;
        if (!acc) $display("FAIL send_accept: in_ready=%0b, required 1 within 20 cycles", in_ready);
        else passed++;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (done) break;
            tick();
        end
        total++;
        if (done !== 1'b1) $display("FAIL done_timeout: done=%0b, required 1 within %0d cycles", done, bound);
        else passed++;
    endtask

    task automatic test_reset();
        got = dut_stats();
        total++;
        if (got !== '0) $display("FAIL reset_stats: got %p, required all zero", got);
        else passed++;
        total++;
        if ({in_ready, busy, done} !== 3'b000)
            $display("FAIL reset_ctrl: in_ready/busy/done=%b, required 000", {in_ready, busy, done});
        else passed++;
    endtask

    task automatic test_exact();
        start_run(4);
        send(12'd1, 12'd2, 13'd3);
        send(12'hFFF, 12'd1, 13'h1000);
        send(12'd0, 12'd0, 13'd0);
        send(12'd7, 12'd8, 13'd15);
        exp_q.push_back(m);
        wait_done(10);
        exp = exp_q.pop_front();
        got = dut_stats();
        total++;
        if (got !== exp) $display("FAIL exact_stats: got %p expected %p", got, exp);
        else passed++;
        total++;
        if (sample_cnt !== 24'd4 || err_cnt !== 24'd0 || sum_abs_err !== '0 || sum_sq_err !== '0 ||
            max_err !== '0 || wce_a !== '0 || wce_b !== '0)
            $display("FAIL exact_plan: cnt=%0d err=%0d sabs=%0d max=%0d, required 4 0 0 0",
                     sample_cnt, err_cnt, sum_abs_err, max_err);
        else passed++;
    endtask

    task automatic test_mixed();
        start_run(3);
        send(12'd5, 12'd3, 13'd6);
        send(12'd10, 12'd10, 13'd25);
        send(12'd4, 12'd4, 13'd8);
        exp_q.push_back(m);
        wait_done(10);
        exp = exp_q.pop_front();
        got = dut_stats();
        total++;
        if (got !== exp) $display("FAIL mixed_stats: got %p expected %p", got, exp);
        else passed++;
        total++;
        if (sample_cnt !== 24'd3 || err_cnt !== 24'd2 || sum_abs_err !== 37'd7 || sum_sq_err !== 50'd29 ||
            max_err !== 13'd5 || wce_a !== 12'd10 || wce_b !== 12'd10)
            $display("FAIL mixed_plan: cnt=%0d err=%0d sabs=%0d ssq=%0d max=%0d wa=%0d wb=%0d, required 3 2 7 29 5 10 10",
                     sample_cnt, err_cnt, sum_abs_err, sum_sq_err, max_err, wce_a, wce_b);
        else passed++;
    endtask

    task automatic test_max_tie();
        start_run(2);
        send(12'hFFF, 12'hFFF, 13'd0);
        send(12'hFFF, 12'hFFF, 13'h1FFE);
        exp_q.push_back(m);
        wait_done(10);
        exp = exp_q.pop_front();
        got = dut_stats();
        total++;
        if (got !== exp) $display("FAIL max_stats: got %p expected %p", got, exp);
        else passed++;
        total++;
        if (max_err !== 13'h1FFE || wce_a !== 12'hFFF || wce_b !== 12'hFFF || err_cnt !== 24'd1)
            $display("FAIL max_plan: max=%0h wa=%0h wb=%0h err=%0d, required 1ffe fff fff 1",
                     max_err, wce_a, wce_b, err_cnt);
        else passed++;

        // Second sample has the same |err| with the opposite sign and other operands.
        start_run(2);
        send(12'hFFF, 12'hFFF, 13'd0);
        send(12'd0, 12'd1, 13'h1FFF);
        exp_q.push_back(m);
        wait_done(10);
        exp = exp_q.pop_front();
        got = dut_stats();
        total++;
        if (got !== exp) $display("FAIL tie_stats: got %p expected %p", got, exp);
        else passed++;
        total++;
        if (max_err !== 13'h1FFE || wce_a !== 12'hFFF || wce_b !== 12'hFFF || err_cnt !== 24'd2)
            $display("FAIL tie_keep: max=%0h wa=%0h wb=%0h err=%0d, required 1ffe fff fff 2",
                     max_err, wce_a, wce_b, err_cnt);
        else passed++;

        start_run(1);
        send(12'd0, 12'd0, 13'h1FFF);
        exp_q.push_back(m);
        wait_done(10);
        exp = exp_q.pop_front();
        got = dut_stats();
        total++;
        if (got !== exp) $display("FAIL max_mag_stats: got %p expected %p", got, exp);
        else passed++;
    endtask

    task automatic test_backpressure();
        int pat[9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
        int naccept;
        bit acc;
        naccept = 0;
        start_run(5);
        for (int i = 0; i < 9; i++) begin
            in_valid = pat[i][0];
            a        = W'($urandom);
            b        = W'($urandom);
            o_approx = (W + 1)'($urandom);
            acc      = in_valid && in_ready;
            if (acc) begin
                model_accept(a, b, o_approx);
                naccept++;
            end
            tick();
            if (acc && naccept == 5) begin
                total++;
                if (in_ready !== 1'b0) $display("FAIL bp_ready_drop: in_ready=%0b, required 0", in_ready);
                else passed++;
                exp_q.push_back(m);
            end
        end
        in_valid = 1'b0;
        total++;
        if (naccept != 5) $display("FAIL bp_accepts: accepted %0d, required 5", naccept);
        else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL bp_done_early: done=%0b one cycle after last accept, required 0", done);
        else passed++;
        tick();
        total++;
        if (done !== 1'b1) $display("FAIL bp_done_latency: done=%0b two cycles after last accept, required 1", done);
        else passed++;
        total++;
        if (exp_q.size() == 0) $display("FAIL bp_stats: no expected entry, required one");
        else begin
            exp = exp_q.pop_front();
            got = dut_stats();
            if (got !== exp) $display("FAIL bp_stats: got %p expected %p", got, exp);
            else passed++;
        end
    endtask

    task automatic test_zero_samples();
        start     = 1'b1;
        n_samples = '0;
        model_clear();
        exp_q.push_back(m);
        tick();
        start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL zero_ctrl: done/busy/in_ready=%b, required 100", {done, busy, in_ready});
        else passed++;
        exp = exp_q.pop_front();
        got = dut_stats();
        total++;
        if (got !== exp) $display("FAIL zero_stats: got %p expected %p", got, exp);
        else passed++;
    endtask

    task automatic test_start_in_run();
        start_run(3);
        send(12'd3, 12'd4, 13'd9);
        start     = 1'b1;
        n_samples = CNT_W'(7);
        tick();
        start     = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1 || sample_cnt !== 24'd1)
            $display("FAIL run_start_ignored: busy=%0b done=%0b in_ready=%0b cnt=%0d, required 1 0 1 1",
                     busy, done, in_ready, sample_cnt);
        else passed++;
        send(12'd1, 12'd1, 13'd2);
        send(12'd2, 12'd2, 13'd5);
        exp_q.push_back(m);
        wait_done(10);
        exp = exp_q.pop_front();
        got = dut_stats();
        total++;
        if (got !== exp) $display("FAIL run_start_stats: got %p expected %p", got, exp);
        else passed++;
    endtask

    task automatic test_reset_mid();
        start_run(4);
        send(12'd1, 12'd1, 13'd0);
        send(12'd2, 12'd2, 13'd0);
        tick();
        rst_n = 1'b0;
        #1;
        got = dut_stats();
        total++;
        if (got !== '0) $display("FAIL midreset_stats: got %p, required all zero", got);
        else passed++;
        total++;
        if ({in_ready, busy, done} !== 3'b000 || dut.state !== IDLE)
            $display("FAIL midreset_ctrl: in_ready/busy/done=%b state=%0d, required 000 and IDLE",
                     {in_ready, busy, done}, dut.state);
        else passed++;
        rst_n = 1'b1;
        tick();
        start_run(1);
        send(12'd1, 12'd1, 13'd3);
        exp_q.push_back(m);
        wait_done(10);
        exp = exp_q.pop_front();
        got = dut_stats();
        total++;
        if (got !== exp) $display("FAIL after_reset_stats: got %p expected %p", got, exp);
        else passed++;
        total++;
        if (err_cnt !== 24'd1 || sum_abs_err !== 37'd1 || max_err !== 13'd1)
            $display("FAIL after_reset_plan: err=%0d sabs=%0d max=%0d, required 1 1 1",
                     err_cnt, sum_abs_err, max_err);
        else passed++;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        n_samples = '0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        o_approx  = '0;
        m         = '0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_exact();
        test_mixed();
        test_max_tie();
        test_backpressure();
        test_zero_samples();
        test_start_in_run();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/approx_add_err_monitor.md
Name: approx_add_err_monitor

Overview:
- Sequential checker that sits on the output side of an approximate unsigned adder (default 12-bit, 13-bit result) under characterization.
- Consumes operand/result triples through a valid/ready handshake.
- Recomputes the exact sum and accumulates error statistics over a programmed sample count: sample count, error count (EP), sum of |err| (MAE), sum of err² (MSE), and max |err| with its operands (WCE).
- Used on FPGA test harnesses to measure the MAE/WCE/EP figures of adder variants in-system.

Parameters:
- W, 12, operand width; approximate result width is W+1.
- CNT_W, 24, width of the sample and error counters and of n_samples.
- SUM_W, CNT_W+W+1, width of the sum_abs_err accumulator.
- SQ_W, CNT_W+2*(W+1), width of the sum_sq_err accumulator.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE.
- n_samples  in  CNT_W  samples per run; sampled on the accepted start.
- in_valid  in  1  the a/b/o_approx triple is valid.
- in_ready  out  1  monitor accepts a triple this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- o_approx  in  W+1  result of the adder under test.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  level; high in DONE.
- sample_cnt  out  CNT_W  samples accumulated.
- err_cnt  out  CNT_W  samples with err != 0.
- sum_abs_err  out  SUM_W  sum of |err|.
- sum_sq_err  out  SQ_W  sum of err².
- max_err  out  W+1  largest |err|.
- wce_a  out  W  operand A of the first sample reaching max_err.
- wce_b  out  W  operand B of that sample.

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is asynchronous, active-low.
- Reset values: every output, counter, accumulator and pipeline register is 0. The FSM resets to IDLE.
- Error arithmetic:
  - exact = a + b, zero-extended to W+1 bits.
  - err = exact − o_approx, signed W+2 bits.
  - |err| is at most 2^(W+1)−1 and fits in W+1 bits.
  - err² is computed from |err|, 2*(W+1) bits.
- Pipeline, latency 2:
  - S1: on accept (in_valid & in_ready), register |err|, the nonzero flag, a and b. Set v1.
  - S2: when v1=1, update the accumulators.
- Accumulation rules:
  - sample_cnt += 1.
  - err_cnt += 1 if err != 0.
  - sum_abs_err += |err|.
  - sum_sq_err += err².
  - If |err| > max_err (strictly greater), load max_err, wce_a and wce_b. Ties keep the earlier sample.
  - All accumulators saturate at all-ones and never wrap.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start, n_samples != 0: clear all statistics and the pipeline, latch n_samples, go to RUN.
  - IDLE/DONE + start, n_samples == 0: clear statistics, go directly to DONE. done stays or becomes 1 next cycle.
  - RUN: in_ready = 1 while accepted < n_samples. On the accept that makes accepted == n_samples, go to DRAIN; in_ready drops in the same cycle the state changes.
  - DRAIN: in_ready = 0. Leave for DONE when v1 == 0 and the last S2 update has completed (exactly 2 cycles after the final accept).
  - DONE: statistics are stable and readable. done = 1 until the next accepted start.
- Handshake rules:
  - in_ready is a registered function of state and the accept counter only; it has no combinational dependency on in_valid.
  - in_valid may gap arbitrarily; a triple is consumed only on in_valid & in_ready.
  - Triples presented outside RUN are ignored.
- start in RUN or DRAIN: ignored, with no effect on statistics.
- Reset mid-run: asynchronous return to IDLE; all statistics are lost (zeroed).
- Output timing: statistics outputs are the live accumulator registers. They are valid only while done = 1.

Decomposition:
- Shared package approx_mon_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - Default width constants W=12, CNT_W=24.
  - A saturating-add function.
- One sub-module, approx_err_calc: the combinational exact-sum / signed-error / |err| / err² slice, reusable by a future subtractor monitor.
- The top holds the FSM, the S1/S2 registers and the accumulators.

Test Plan:
- Exact results: start with n_samples=4; feed (1,2,3), (0xFFF,1,0x1000), (0,0,0), (7,8,15) -> done, sample_cnt=4, err_cnt=0, sum_abs_err=0, sum_sq_err=0, max_err=0, wce_a=wce_b=0.
- Mixed errors: n_samples=3; feed (5,3,6), (10,10,25), (4,4,8) -> sample_cnt=3, err_cnt=2, sum_abs_err=7, sum_sq_err=29, max_err=5, wce_a=10, wce_b=10.
- Maximum error and tie: n_samples=2; feed (0xFFF,0xFFF,0) then (0xFFF,0xFFF,0x1FFE) -> max_err=0x1FFE, wce_a=wce_b=0xFFF from the first sample, err_cnt=1; a further equal-error sample must not change wce_a/wce_b.
- Backpressure and gaps:
  - n_samples=5; in_valid toggles 1,0,0,1,1,0,1,1,1 -> exactly 5 accepts.
  - in_ready low from the cycle after the 5th accept.
  - done rises exactly 2 cycles after the 5th accept; the extra valid triple is ignored.
- Boundary controls:
  - n_samples=0 -> done next cycle with all statistics 0.
  - start pulsed during RUN -> no restart; counts unchanged.
- Reset mid-run: rst_n low after 2 of 4 samples -> all outputs 0 and the state is IDLE immediately, without waiting for a clock edge; a fresh start with n_samples=1 and (1,1,3) -> err_cnt=1, sum_abs_err=1, max_err=1.
